vga_rx: RTL and testbench

VGA_RX -- requirements
Module: vga_rx

---
 rtl/vga_rx.sv | 199 +++++++++++++++++++
 tb/tb_vga_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx.sv
// VGA timing receiver: registers raw sync/pixel inputs, measures line and frame
// periods, locks onto H_TOT x V_TOT timing and tags visible pixels with x/y.
module vga_rx #(
  parameter int unsigned H_TOT       = 800,
  parameter int unsigned V_TOT       = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        active,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic [11:0] pix_data,
  output logic        pix_valid,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        locked,
  output logic        err,
  output logic [9:0]  h_meas,
  output logic [9:0]  v_meas
);
  localparam int unsigned CW      = $clog2(LOCK_FRAMES + 2);
  localparam logic [9:0]  SAT     = '1;
  localparam logic [9:0]  H_EXP   = 10'(H_TOT);
  localparam logic [9:0]  V_EXP   = 10'(V_TOT);
  localparam logic [CW-1:0] L_EXP = CW'(LOCK_FRAMES);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_CHECK, ST_LOCKED} state_t;

  logic          r_hs1, r_hs2, r_vs1, r_vs2, r_act1, r_act2;
  logic [11:0]   r_rgb1;
  logic [9:0]    r_hcnt, r_hmeas, r_lines, r_vmeas;
  logic          r_hseen, r_fbad;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_gcnt, w_gcnt_nxt, w_gcnt_inc;
  logic          r_err, w_err_nxt, r_locked;
  logic [11:0]   r_pix;
  logic          r_valid;
  logic [9:0]    r_x, r_y, r_xcnt, r_ycnt;

  logic          w_hs_fall, w_vs_fall, w_act_fall, w_line_bad, w_frame_good, w_sat;
  logic [10:0]   w_vsum;
  logic [9:0]    w_vcap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs1  <= 1'b1;
      r_hs2  <= 1'b1;
      r_vs1  <= 1'b1;
      r_vs2  <= 1'b1;
      r_act1 <= 1'b0;
      r_act2 <= 1'b0;
      r_rgb1 <= '0;
    end else begin
      r_hs1  <= hsync;
      r_hs2  <= r_hs1;
      r_vs1  <= vsync;
      r_vs2  <= r_vs1;
      r_act1 <= active;
      r_act2 <= r_act1;
      r_rgb1 <= {red, green, blue};
    end
  end

  assign w_hs_fall  = r_hs2 & ~r_hs1;
  assign w_vs_fall  = r_vs2 & ~r_vs1;
  assign w_act_fall = r_act2 & ~r_act1;

  // The first hsync edge after reset only starts the count; it is never judged.
  assign w_line_bad = w_hs_fall & r_hseen & (r_hcnt != H_EXP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt  <= '0;
      r_hmeas <= '0;
      r_hseen <= 1'b0;
    end else if (w_hs_fall) begin
      r_hcnt  <= 10'd1;
      r_hseen <= 1'b1;
      if (r_hseen) r_hmeas <= r_hcnt;
    end else if (r_hcnt != SAT) begin
      r_hcnt <= r_hcnt + 10'd1;
    end
  end

  assign w_vsum = {1'b0, r_lines} + {10'd0, w_hs_fall};
  assign w_vcap = w_vsum[10] ? SAT : w_vsum[9:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lines <= '0;
      r_vmeas <= '0;
      r_fbad  <= 1'b0;
    end else if (w_vs_fall) begin
      r_vmeas <= w_vcap;
      r_lines <= {9'd0, w_hs_fall};
      r_fbad  <= 1'b0;
    end else begin
      r_lines <= w_vcap;
      if (w_line_bad) r_fbad <= 1'b1;
    end
  end

  assign w_frame_good = (w_vcap == V_EXP) & ~r_fbad & ~w_line_bad;
  assign w_sat        = (r_lines == SAT) | (r_hcnt == SAT);
  assign w_gcnt_inc   = r_gcnt + CW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_gcnt_nxt  = r_gcnt;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_vs_fall) begin
          w_state_nxt = ST_CHECK;
          w_gcnt_nxt  = '0;
        end
      end
      ST_CHECK: begin
        if (w_vs_fall) begin
          if (w_frame_good) begin
            w_gcnt_nxt = w_gcnt_inc;
            if (w_gcnt_inc == L_EXP) w_state_nxt = ST_LOCKED;
          end else begin
            w_gcnt_nxt = '0;
          end
        end
      end
      ST_LOCKED: begin
        if ((w_vs_fall & ~w_frame_good) | w_sat) begin
          w_state_nxt = ST_UNLOCKED;
          w_err_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_UNLOCKED;
      r_gcnt   <= '0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gcnt   <= w_gcnt_nxt;
      r_err    <= w_err_nxt;
      r_locked <= (w_state_nxt == ST_LOCKED);
    end
  end

  // x/y only move when the pixel will be flagged valid, so they hold while pix_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix   <= '0;
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_xcnt  <= '0;
    end else if (r_act1) begin
      r_pix   <= r_rgb1;
      r_valid <= r_locked;
      if (r_locked) begin
        r_x <= r_xcnt;
        r_y <= r_ycnt;
      end
      if (r_xcnt != SAT) r_xcnt <= r_xcnt + 10'd1;
    end else begin
      r_xcnt  <= '0;
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ycnt <= '0;
    end else if (w_vs_fall) begin
      r_ycnt <= '0;
    end else if (w_act_fall && (r_ycnt != SAT)) begin
      r_ycnt <= r_ycnt + 10'd1;
    end
  end

  assign pix_data    = r_pix;
  assign pix_valid   = r_valid;
  assign x           = r_x;
  assign y           = r_y;
  assign frame_start = r_valid & (r_x == '0) & (r_y == '0);
  assign locked      = r_locked;
  assign err         = r_err;
  assign h_meas      = r_hmeas;
  assign v_meas      = r_vmeas;

endmodule

// File: tb/tb_vga_rx.sv
// Scoreboard bench for vga_rx on a scaled-down raster: a frame-level model decides
// which pixels are expected valid; a negedge monitor pops and compares them.
module tb_vga_rx;
  localparam int H  = 20;
  localparam int V  = 12;
  localparam int LF = 2;
  localparam int VW = 14;
  localparam int VL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync = 1'b1, vsync = 1'b1, active = 1'b0;
  logic [3:0]  red = '0, green = '0, blue = '0;
  logic [11:0] pix_data;
  logic        pix_valid, frame_start, locked, err;
  logic [9:0]  x, y, h_meas, v_meas;

  vga_rx #(.H_TOT(H), .V_TOT(V), .LOCK_FRAMES(LF)) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .active(active),
    .red(red), .green(green), .blue(blue),
    .pix_data(pix_data), .pix_valid(pix_valid), .x(x), .y(y),
    .frame_start(frame_start), .locked(locked), .err(err),
    .h_meas(h_meas), .v_meas(v_meas)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  px;
    logic [9:0]  py;
    logic [11:0] d;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  // Frame-level reference model state
  bit   armed, hseen, last_good;
  int   run, exp_err, err_seen, hmeas_e, vmeas_e, hs_since, prev_len;

  function automatic void chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endfunction

  function automatic bit m_locked();
    return armed && (run >= LF);
  endfunction

  function automatic void model_reset();
    armed    = 1'b0;
    run      = 0;
    hseen    = 1'b0;
    hmeas_e  = 0;
    vmeas_e  = 0;
    hs_since = 0;
    sbq.delete();
  endfunction

  function automatic void m_line_start();
    if (hseen) hmeas_e = prev_len;
    hseen = 1'b1;
    if (hs_since < 1023) hs_since++;
  endfunction

  function automatic void m_vs_event();
    vmeas_e  = hs_since;
    hs_since = 0;
    if (!armed) begin
      armed = 1'b1;
      run   = 0;
    end else if (m_locked()) begin
      if (!last_good) begin
        armed = 1'b0;
        run   = 0;
        exp_err++;
      end
    end else if (last_good) begin
      run++;
    end else begin
      run = 0;
    end
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_pix_data"},    int'(pix_data), 0);
    chk({tag, "_pix_valid"},   int'(pix_valid), 0);
    chk({tag, "_x"},           int'(x), 0);
    chk({tag, "_y"},           int'(y), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_locked"},      int'(locked), 0);
    chk({tag, "_err"},         int'(err), 0);
    chk({tag, "_h_meas"},      int'(h_meas), 0);
    chk({tag, "_v_meas"},      int'(v_meas), 0);
  endtask

  task automatic drive_line(input int l, input int len, input bit vs_on,
                            input int rst_c, input bit fc0);
    for (int c = 0; c < len; c++) begin
      bit          a;
      logic [11:0] rgb;
      exp_t        e;
      if (c == 0) m_line_start();
      if (c == 8) begin
        chk("h_meas", int'(h_meas), hmeas_e);
        if (vs_on) chk("locked", int'(locked), int'(m_locked()));
        if (vs_on && l == 5) begin
          chk("v_meas", int'(v_meas), vmeas_e);
          chk("err_count", err_seen, exp_err);
        end
      end
      if (c == rst_c) begin
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        model_reset();
      end
      hsync = (c >= 2);
      vsync = vs_on ? !((l == 0 && c >= 1) || l == 1 || (l == 2 && c < 1)) : 1'b1;
      if (vs_on && l == 0 && c == 1) m_vs_event();
      a   = vs_on && l >= 3 && l < 3 + VL && c >= 4 && c < 4 + VW;
      rgb = 12'($urandom);
      if (fc0 && l == 2 + VL && c == 3 + VW) rgb = 12'hFC0;
      active = a;
      {red, green, blue} = rgb;
      if (a && m_locked()) begin
        e.px = 10'(c - 4);
        e.py = 10'(l - 3);
        e.d  = rgb;
        sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
    prev_len = len;
  endtask

  task automatic frame(input int short_l, input int short_len, input int rst_l, input bit fc0);
    bit good;
    good = 1'b1;
    for (int l = 0; l < V; l++) begin
      int len;
      len = (l == short_l) ? short_len : H;
      if (len != H) good = 1'b0;
      drive_line(l, len, 1'b1, (l == rst_l) ? 8 : -1, fc0);
    end
    last_good = good;
  endtask

  task automatic stuck(input int n);
    for (int i = 0; i < n; i++) drive_line(3, H, 1'b0, -1, 1'b0);
    if (m_locked()) begin
      armed = 1'b0;
      run   = 0;
      exp_err++;
    end
    last_good = 1'b0;
  endtask

  // Monitor: pops the scoreboard for every valid pixel, checks hold behaviour otherwise
  logic [9:0] px_prev = '0, py_prev = '0;
  logic       err_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (err) begin
      chk("err_width", int'(err_prev), 0);
      err_seen++;
    end
    if (pix_valid) begin
      if (sbq.size() == 0) begin
        chk("pix_unexpected", int'(pix_valid), 0);
      end else begin
        e = sbq.pop_front();
        chk("pix_x", int'(x), int'(e.px));
        chk("pix_y", int'(y), int'(e.py));
        chk("pix_data", int'(pix_data), int'(e.d));
        chk("frame_start", int'(frame_start), int'(e.px == 10'd0 && e.py == 10'd0));
      end
    end else begin
      chk("frame_start_idle", int'(frame_start), 0);
      if (!rst) begin
        chk("x_hold", int'(x), int'(px_prev));
        chk("y_hold", int'(y), int'(py_prev));
      end
    end
    px_prev  = x;
    py_prev  = y;
    err_prev = err;
  end

  initial begin
    model_reset();
    exp_err   = 0;
    err_seen  = 0;
    prev_len  = 0;
    last_good = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst_init");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("idle");

    for (int f = 0; f < 5; f++) frame(-1, 0, -1, f == 3);
    frame(6, 19, -1, 1'b0);
    for (int f = 0; f < 5; f++) frame(-1, 0, -1, 1'b0);
    stuck(1030);
    for (int f = 0; f < 4; f++) frame(-1, 0, -1, 1'b0);
    frame(-1, 0, 6, 1'b0);
    for (int f = 0; f < 4; f++) frame(-1, 0, -1, f == 3);
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 3) == 0)
        frame(int'($urandom_range(0, V - 1)), 18 + int'($urandom_range(0, 4)), -1, 1'b0);
      else
        frame(-1, 0, -1, 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 0);
    chk("err_total", err_seen, exp_err);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
